vga_sprite_engine: RTL and testbench

Parametrised successor to the fixed-bitmap VGA renderer: generates VGA timing and composites one animated, integer-scaled sprite over a solid background, driving the 8-bit VGA PMOD. Sprite pixels come from an external synchronous ROM through a registered address port, so the colour path is pipelined and the syncs are delayed to match. Sprite position can move every frame and bounce off the screen edges. Sits at top level between the ROM/bitmap include and the PMOD pins.

---
 rtl/vga_sprite_engine.sv | 210 +++++++++++++++++++++
 tb/tb_vga_sprite_engine.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_engine.sv
// rtl/vga_sprite_engine.sv - VGA timing with one animated, integer-scaled sprite over a solid background
// Optional feature macro: SPRITE_BOUNCE_EN (sprite moves STEP px/frame and bounces off the screen edges;
//   when undefined the sprite sits fixed at INIT_X/INIT_Y).
// Ports:
//   clk          pixel clock
//   rst_n        synchronous, active-low reset
//   rom_addr     registered sprite ROM address {anim, by, bx}; holds when the sprite is not hit
//   rom_data     ROM word {opaque, r[1:0], g[1:0], b[1:0]}, valid the cycle after rom_addr is sampled
//   vga_pmod     {hsync, b[0], g[0], r[0], vsync, b[1], g[1], r[1]}, 3 cycles behind the counters
//   frame_start  high in the cycle the counters sit at (0,0)
module vga_sprite_engine #(
  parameter int VGA_WIDTH     = 640,
  parameter int VGA_HEIGHT    = 480,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_PULSE  = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_PULSE  = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter int SPRITE_W      = 34,
  parameter int SPRITE_H      = 22,
  parameter int SCALE_BITS    = 3,
  parameter int FRAMES        = 2,
  parameter int FRAME_HOLD    = 16,
  parameter int INIT_X        = 128,
  parameter int INIT_Y        = 128,
  parameter int STEP          = 2,
  parameter logic [5:0] BG_COLOR = 6'b000111,
  localparam int AXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
  localparam int AYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1,
  localparam int AAW = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int AW  = AAW + AYW + AXW
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] rom_addr,
  input  logic [6:0]    rom_data,
  output logic [7:0]    vga_pmod,
  output logic          frame_start
);

  localparam int HT  = VGA_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
  localparam int VT  = VGA_HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
  localparam int XW  = $clog2(HT);
  localparam int YW  = $clog2(VT);
  localparam int HDW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;
  logic [HDW-1:0] r_hold;
  logic [AAW-1:0] r_anim;
  logic [XW-1:0]  w_px;
  logic [YW-1:0]  w_py;
  logic           w_line_end;
  logic           w_frame_end;

  assign w_line_end  = (r_x == XW'(HT - 1));
  assign w_frame_end = w_line_end && (r_y == YW'(VT - 1));
  assign frame_start = rst_n && (r_x == '0) && (r_y == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_line_end) begin
      r_x <= '0;
      r_y <= w_frame_end ? '0 : r_y + YW'(1);
    end else begin
      r_x <= r_x + XW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold <= '0;
      r_anim <= '0;
    end else if (w_frame_end) begin
      if (r_hold == HDW'(FRAME_HOLD - 1)) begin
        r_hold <= '0;
        r_anim <= (r_anim == AAW'(FRAMES - 1)) ? '0 : r_anim + AAW'(1);
      end else begin
        r_hold <= r_hold + HDW'(1);
      end
    end
  end

`ifdef SPRITE_BOUNCE_EN
  // One extra bit so px+STEP cannot wrap before the edge comparison.
  localparam int XW1 = XW + 1;
  localparam int YW1 = YW + 1;
  localparam logic [XW1-1:0] MAX_X  = XW1'(VGA_WIDTH - (SPRITE_W << SCALE_BITS));
  localparam logic [YW1-1:0] MAX_Y  = YW1'(VGA_HEIGHT - (SPRITE_H << SCALE_BITS));
  localparam logic [XW1-1:0] STEP_X = XW1'(STEP);
  localparam logic [YW1-1:0] STEP_Y = YW1'(STEP);

  logic [XW-1:0] r_px;
  logic [YW-1:0] r_py;
  logic          r_left;
  logic          r_up;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_px   <= XW'(INIT_X);
      r_py   <= YW'(INIT_Y);
      r_left <= 1'b0;
      r_up   <= 1'b0;
    end else if (w_frame_end) begin
      if (!r_left) begin
        if ({1'b0, r_px} + STEP_X >= MAX_X) begin
          r_px   <= MAX_X[XW-1:0];
          r_left <= 1'b1;
        end else begin
          r_px <= r_px + STEP_X[XW-1:0];
        end
      end else begin
        if ({1'b0, r_px} <= STEP_X) begin
          r_px   <= '0;
          r_left <= 1'b0;
        end else begin
          r_px <= r_px - STEP_X[XW-1:0];
        end
      end
      if (!r_up) begin
        if ({1'b0, r_py} + STEP_Y >= MAX_Y) begin
          r_py <= MAX_Y[YW-1:0];
          r_up <= 1'b1;
        end else begin
          r_py <= r_py + STEP_Y[YW-1:0];
        end
      end else begin
        if ({1'b0, r_py} <= STEP_Y) begin
          r_py <= '0;
          r_up <= 1'b0;
        end else begin
          r_py <= r_py - STEP_Y[YW-1:0];
        end
      end
    end
  end

  assign w_px = r_px;
  assign w_py = r_py;
`else
  assign w_px = XW'(INIT_X);
  assign w_py = YW'(INIT_Y);
`endif

  // Stage 1: hit test, ROM address, raw syncs and active flag for the current counters.
  logic [XW-1:0]  w_dx;
  logic [YW-1:0]  w_dy;
  logic [AXW-1:0] w_bx;
  logic [AYW-1:0] w_by;
  logic           w_hit;
  logic           w_active;
  logic           w_hs;
  logic           w_vs;

  assign w_dx     = r_x - w_px;
  assign w_dy     = r_y - w_py;
  assign w_bx     = AXW'(w_dx >> SCALE_BITS);
  assign w_by     = AYW'(w_dy >> SCALE_BITS);
  assign w_hit    = (int'(r_x) >= int'(w_px)) && (int'(w_dx) < (SPRITE_W << SCALE_BITS)) &&
                    (int'(r_y) >= int'(w_py)) && (int'(w_dy) < (SPRITE_H << SCALE_BITS));
  assign w_active = (int'(r_x) < VGA_WIDTH) && (int'(r_y) < VGA_HEIGHT);
  assign w_hs     = !((int'(r_x) >= VGA_WIDTH + H_FRONT_PORCH) &&
                      (int'(r_x) <  VGA_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE));
  assign w_vs     = !((int'(r_y) >= VGA_HEIGHT + V_FRONT_PORCH) &&
                      (int'(r_y) <  VGA_HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE));

  logic [AW-1:0] r_rom_addr;
  logic          r1_hit, r1_active, r1_hs, r1_vs;
  logic          r2_hit, r2_active, r2_hs, r2_vs;
  logic [7:0]    r_pmod;
  logic [5:0]    w_color;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rom_addr <= '0;
      r1_hit     <= 1'b0;
      r1_active  <= 1'b0;
      r1_hs      <= 1'b1;
      r1_vs      <= 1'b1;
      r2_hit     <= 1'b0;
      r2_active  <= 1'b0;
      r2_hs      <= 1'b1;
      r2_vs      <= 1'b1;
      r_pmod     <= 8'h88;
    end else begin
      if (w_hit) begin
        r_rom_addr <= {r_anim, w_by, w_bx};
      end
      r1_hit    <= w_hit;
      r1_active <= w_active;
      r1_hs     <= w_hs;
      r1_vs     <= w_vs;
      // Stage 2 waits out the ROM read so flags line up with rom_data.
      r2_hit    <= r1_hit;
      r2_active <= r1_active;
      r2_hs     <= r1_hs;
      r2_vs     <= r1_vs;
      r_pmod    <= {r2_hs, w_color[0], w_color[2], w_color[4],
                    r2_vs, w_color[1], w_color[3], w_color[5]};
    end
  end

  assign w_color  = !r2_active ? 6'd0 : (r2_hit && rom_data[6]) ? rom_data[5:0] : BG_COLOR;
  assign rom_addr = r_rom_addr;
  assign vga_pmod = r_pmod;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// tb/tb_vga_sprite_engine.sv - randomized self-checking bench for vga_sprite_engine against a behavioural model
module tb_vga_sprite_engine;
  localparam int W = 48, H = 32, HFP = 4, HSP = 6, HBP = 4, VFP = 2, VSP = 2, VBP = 3;
  localparam int SW = 5, SH = 3, SB = 1, NF = 2, FH = 2, ST = 2;
  localparam int HT = 62, VT = 39, FRAME_CYC = 2418;
  localparam int MAXX = 38, MAXY = 26;
  localparam int IX = MAXX - 3, IY = 20;
  localparam int AXW = 3, AYW = 2, AW = 6;
  localparam logic [5:0] BG = 6'b000111;
`ifdef SPRITE_BOUNCE_EN
  localparam int PX1 = 37, PX2 = 38, PX3 = 36, PY3 = 26;
`else
  localparam int PX1 = 35, PX2 = 35, PX3 = 35, PY3 = 20;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [6:0]    rom_data;
  logic [7:0]    vga_pmod;
  logic          frame_start;
  logic [6:0]    rom_mem [64];

  vga_sprite_engine #(
    .VGA_WIDTH(W), .VGA_HEIGHT(H),
    .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSP), .H_BACK_PORCH(HBP),
    .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSP), .V_BACK_PORCH(VBP),
    .SPRITE_W(SW), .SPRITE_H(SH), .SCALE_BITS(SB), .FRAMES(NF), .FRAME_HOLD(FH),
    .INIT_X(IX), .INIT_Y(IY), .STEP(ST), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .vga_pmod(vga_pmod), .frame_start(frame_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int n_chk = 0, n_pass = 0;
  int phase = 0, cyc = 0;
  int m_x, m_y, m_px, m_py, m_hold, m_anim, m_addr, frames, pc;
  bit m_left, m_up, model_valid = 1'b0;
  logic [7:0] q[$];
  int hs_run = 0, vs_low = 0, fs_cnt = 0, fs_last = -1, bg_cnt = 0;
  bit hs_start_done = 0, hs_len_done = 0, fs_per_done = 0;
  int pend_due[$], pend_exp[$], pend_kind[$];
  string pend_name[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
  endtask

  task automatic pend(input int due, input int kind, input int exp, input string name);
    pend_due.push_back(due); pend_kind.push_back(kind); pend_exp.push_back(exp); pend_name.push_back(name);
  endtask

  function automatic logic [7:0] pack(input bit hs, input bit vs, input logic [5:0] c);
    return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_hold = 0; m_anim = 0; m_px = IX; m_py = IY;
    m_left = 0; m_up = 0; m_addr = 0; frames = 0; pc = 0;
    q.delete();
    repeat (3) q.push_back(8'h88);
    model_valid = 1'b1;
  endtask

  task automatic frame_wrap();
    m_hold++;
    if (m_hold == FH) begin
      m_hold = 0;
      m_anim = (m_anim + 1) % NF;
    end
`ifdef SPRITE_BOUNCE_EN
    if (!m_left) begin
      if (m_px + ST >= MAXX) begin m_px = MAXX; m_left = 1; end else m_px += ST;
    end else begin
      if (m_px <= ST) begin m_px = 0; m_left = 0; end else m_px -= ST;
    end
    if (!m_up) begin
      if (m_py + ST >= MAXY) begin m_py = MAXY; m_up = 1; end else m_py += ST;
    end else begin
      if (m_py <= ST) begin m_py = 0; m_up = 0; end else m_py -= ST;
    end
`endif
    frames++;
    if (phase == 3) begin
      if (frames == 1) begin chk("model_px_f1", m_px, PX1); chk("model_anim_f1", m_anim, 0); end
      if (frames == 2) begin chk("model_px_f2", m_px, PX2); chk("model_anim_f2", m_anim, 1); end
      if (frames == 3) begin chk("model_px_f3", m_px, PX3); chk("model_py_f3", m_py, PY3); end
      if (frames == 4) chk("model_anim_f4", m_anim, 0);
    end
  endtask

  task automatic model_step();
    bit hs, vs, act, hit;
    int a;
    logic [6:0] w;
    logic [5:0] col;
    hs  = !(m_x >= W + HFP && m_x < W + HFP + HSP);
    vs  = !(m_y >= H + VFP && m_y < H + VFP + VSP);
    act = (m_x < W) && (m_y < H);
    hit = (m_x >= m_px) && (m_x < m_px + SW * (1 << SB)) && (m_y >= m_py) && (m_y < m_py + SH * (1 << SB));
    a = 0; w = 7'd0; col = 6'd0;
    if (hit) begin
      a = m_anim * (1 << (AYW + AXW)) + ((m_y - m_py) / (1 << SB)) * (1 << AXW) + (m_x - m_px) / (1 << SB);
      w = rom_mem[a];
    end
    if (act) col = (hit && w[6]) ? w[5:0] : BG;
    q.push_back(pack(hs, vs, col));
    void'(q.pop_front());
    if (hit) m_addr = a;
    if (phase == 1 && frames == 0) begin
      if (m_x == 35 && m_y == 20) pend(cyc + 3, 0, 8'h99, "pix_35_20_red");
      if (m_x == 34 && m_y == 20) pend(cyc + 3, 0, 8'hEC, "pix_34_20_bg");
      if (m_x == 48 && m_y == 0)  pend(cyc + 3, 0, 8'h88, "pix_48_0_blank");
    end
    if (phase == 3 && frames == 0 && m_x == 39 && m_y == 22) pend(cyc + 1, 1, 10, "rom_addr_39_22");
    pc++;
    if (m_x == HT - 1) begin
      m_x = 0;
      if (m_y == VT - 1) begin m_y = 0; frame_wrap(); end else m_y++;
    end else begin
      m_x++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (model_valid) begin
        chk("pmod", vga_pmod, q[0]);
        chk("rom_addr", rom_addr, m_addr);
        chk("frame_start", frame_start, int'(rst_n && m_x == 0 && m_y == 0));
        while (pend_due.size() > 0 && pend_due[0] <= cyc) begin
          if (pend_kind[0] == 0) chk(pend_name[0], vga_pmod, pend_exp[0]);
          else chk(pend_name[0], rom_addr, pend_exp[0]);
          void'(pend_due.pop_front()); void'(pend_kind.pop_front());
          void'(pend_exp.pop_front()); void'(pend_name.pop_front());
        end
        if (phase == 1) begin
          if (!vga_pmod[7]) begin
            if (hs_run == 0 && !hs_start_done) begin chk("hsync_start_x", m_x, 55); hs_start_done = 1; end
            hs_run++;
          end else begin
            if (hs_run > 0 && !hs_len_done) begin chk("hsync_len", hs_run, 6); hs_len_done = 1; end
            hs_run = 0;
          end
          if (!vga_pmod[3]) vs_low++;
          if (frame_start) begin
            if (fs_last >= 0 && !fs_per_done) begin chk("frame_period", cyc - fs_last, FRAME_CYC); fs_per_done = 1; end
            fs_last = cyc;
            fs_cnt++;
          end
        end
        if (phase == 2 && pc >= 3 && pc < 3 + FRAME_CYC && (vga_pmod & 8'h77) == 8'h64) bg_cnt++;
      end
      if (!rst_n) model_reset();
      else if (model_valid) model_step();
    end
  end

  initial begin
    bit found;
    foreach (rom_mem[i]) rom_mem[i] = 7'h70;
    phase = 1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pmod", vga_pmod, 8'h88);
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_frame_start", frame_start, 0);
    rst_n = 1'b1;
    repeat (FRAME_CYC + 10) @(posedge clk);
    #1;
    chk("vsync_low_cycles", vs_low, 124);
    chk("frame_start_count", fs_cnt, 2);
    chk("hsync_seen", int'(hs_start_done && hs_len_done), 1);

    rst_n = 1'b0;
    phase = 2;
    @(posedge clk);
    #1;
    foreach (rom_mem[i]) rom_mem[i] = {1'b0, 6'($urandom)};
    rst_n = 1'b1;
    repeat (FRAME_CYC + 10) @(posedge clk);
    #1;
    chk("transparent_bg_pixels", bg_cnt, 1536);

    rst_n = 1'b0;
    phase = 3;
    @(posedge clk);
    #1;
    foreach (rom_mem[i]) rom_mem[i] = 7'($urandom);
    rst_n = 1'b1;
    repeat (6 * FRAME_CYC) @(posedge clk);
    found = 0;
    for (int i = 0; i < FRAME_CYC + 10 && !found; i++) begin
      @(posedge clk);
      #1;
      if (m_x == 30 && m_y == 5) found = 1;
    end
    chk("midline_point_reached", int'(found), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("midline_reset_pmod", vga_pmod, 8'h88);
    chk("midline_reset_frame_start", frame_start, 1);
    chk("midline_reset_rom_addr", rom_addr, 0);
    repeat (2 * FRAME_CYC + 20) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
